// File: rtl/rx9_io40_gather.sv
// Receive-side gatherer: locks onto a lane-0 training marker and rebuilds
// nine 40-bit words from four consecutive 10-bit slices per lane.
module rx9_io40_gather #(
  parameter logic [9:0]  MARK     = 10'h17C,
  parameter int unsigned LOCK_CNT = 8
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_rx_locked,
  input  logic        I_realign,
  input  logic [89:0] I_rx_in,
  output logic [39:0] O_o0_p,
  output logic [39:0] O_o1_p,
  output logic [39:0] O_o2_p,
  output logic [39:0] O_o3_p,
  output logic [39:0] O_o4_p,
  output logic [39:0] O_o5_p,
  output logic [39:0] O_o6_p,
  output logic [39:0] O_o7_p,
  output logic [39:0] O_o8_p,
  output logic        O_valid,
  output logic        O_aligned,
  output logic [1:0]  O_phase
);

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_HUNT,
    S_CONFIRM,
    S_ALIGNED
  } state_e;

  localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);

  state_e      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [1:0]  wphase;
  logic [7:0]  hit_q, hit_d;
  logic        valid_q, load;
  logic        mark0;
  logic [29:0] stage_q [9];
  logic [39:0] word_q  [9];

  assign mark0 = (I_rx_in[9:0] == MARK);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 2'd1;
    hit_d   = hit_q;
    wphase  = phase_q;
    case (state_q)
      S_WAIT_LOCK: if (I_rx_locked) state_d = S_HUNT;
      S_HUNT: begin
        // The marker itself is slice 0, so it is staged as phase 0 this cycle.
        if (mark0) begin
          phase_d = 2'd1;
          wphase  = 2'd0;
          hit_d   = 8'd1;
          state_d = (LOCK_N == 8'd1) ? S_ALIGNED : S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        if (phase_q == 2'd0) begin
          if (mark0) begin
            hit_d = hit_q + 8'd1;
            if (hit_q + 8'd1 == LOCK_N) state_d = S_ALIGNED;
          end else begin
            hit_d   = '0;
            state_d = S_HUNT;
          end
        end
      end
      default: ;
    endcase
    if (I_realign && (state_q == S_CONFIRM || state_q == S_ALIGNED)) begin
      state_d = S_HUNT;
      hit_d   = '0;
    end
    if (!I_rx_locked) begin
      state_d = S_WAIT_LOCK;
      hit_d   = '0;
      phase_d = phase_q + 2'd1;
    end
    load = (state_q == S_ALIGNED) && (phase_q == 2'd3) && I_rx_locked && !I_realign;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_WAIT_LOCK;
      phase_q <= '0;
      hit_q   <= '0;
      valid_q <= 1'b0;
      for (int unsigned l = 0; l < 9; l++) begin
        stage_q[l] <= '0;
        word_q[l]  <= '0;
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hit_q   <= hit_d;
      valid_q <= load;
      for (int unsigned l = 0; l < 9; l++) begin
        case (wphase)
          2'd0:    stage_q[l][9:0]   <= I_rx_in[10*l +: 10];
          2'd1:    stage_q[l][19:10] <= I_rx_in[10*l +: 10];
          2'd2:    stage_q[l][29:20] <= I_rx_in[10*l +: 10];
          default: ;
        endcase
        if (load) word_q[l] <= {I_rx_in[10*l +: 10], stage_q[l]};
      end
    end
  end

  assign O_o0_p    = word_q[0];
  assign O_o1_p    = word_q[1];
  assign O_o2_p    = word_q[2];
  assign O_o3_p    = word_q[3];
  assign O_o4_p    = word_q[4];
  assign O_o5_p    = word_q[5];
  assign O_o6_p    = word_q[6];
  assign O_o7_p    = word_q[7];
  assign O_o8_p    = word_q[8];
  assign O_valid   = valid_q;
  assign O_aligned = (state_q == S_ALIGNED);
  assign O_phase   = phase_q;

endmodule

// File: tb/tb_rx9_io40_gather.sv
// Scoreboard bench for rx9_io40_gather: directed slices in, expected words
// queued by the driver and popped by a monitor on every O_valid.
module tb_rx9_io40_gather;

  localparam logic [9:0] MARK = 10'h17C;

  logic        I_clk = 1'b0;
  logic        I_rst_n;
  logic        I_rx_locked;
  logic        I_realign;
  logic [89:0] I_rx_in;
  logic [39:0] O_o0_p, O_o1_p, O_o2_p, O_o3_p, O_o4_p, O_o5_p, O_o6_p, O_o7_p, O_o8_p;
  logic        O_valid;
  logic        O_aligned;
  logic [1:0]  O_phase;

  int n_cmp = 0;
  int n_err = 0;
  logic [359:0] sb [$];
  logic [359:0] last_w;

  rx9_io40_gather #(.MARK(MARK), .LOCK_CNT(8)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_rx_locked(I_rx_locked),
    .I_realign(I_realign), .I_rx_in(I_rx_in),
    .O_o0_p(O_o0_p), .O_o1_p(O_o1_p), .O_o2_p(O_o2_p), .O_o3_p(O_o3_p),
    .O_o4_p(O_o4_p), .O_o5_p(O_o5_p), .O_o6_p(O_o6_p), .O_o7_p(O_o7_p),
    .O_o8_p(O_o8_p), .O_valid(O_valid), .O_aligned(O_aligned), .O_phase(O_phase)
  );

  always #5 I_clk = ~I_clk;

  function automatic logic [359:0] outs();
    return {O_o8_p, O_o7_p, O_o6_p, O_o5_p, O_o4_p, O_o3_p, O_o2_p, O_o1_p, O_o0_p};
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Training word: lane 0 carries MARK in slice 0 and non-markers elsewhere.
  function automatic logic [359:0] tword(input int k);
    logic [359:0] w;
    for (int l = 1; l < 9; l++)
      w[40*l +: 40] = {8'(k), 8'(l), 24'hC0FFEE ^ 24'(l * 7)};
    w[39:0] = {10'h3C3, 10'h0F0, 10'(k), MARK};
    return w;
  endfunction

  function automatic logic [359:0] dword(input int k);
    logic [359:0] w;
    for (int l = 0; l < 9; l++)
      w[40*l +: 40] = {8'(k + 1), 4'(l), 28'h9E3779B + 28'(l * 37 + k)};
    return w;
  endfunction

  task automatic cyc(input logic [89:0] v);
    I_rx_in = v;
    @(posedge I_clk);
    #1;
  endtask

  task automatic send_part(input logic [359:0] w, input int lo, input int hi);
    logic [89:0] v;
    for (int s = lo; s <= hi; s++) begin
      for (int l = 0; l < 9; l++) v[10*l +: 10] = w[40*l + 10*s +: 10];
      cyc(v);
    end
  endtask

  task automatic send(input logic [359:0] w, input bit exp);
    if (exp) begin
      sb.push_back(w);
      last_w = w;
    end
    send_part(w, 0, 3);
  endtask

  // Send LOCK_CNT training words; the 8th completes lock and is delivered.
  task automatic train(input int base);
    for (int k = 0; k < 7; k++) send(tword(base + k), 1'b0);
    chk("aligned_before_8th", {39'd0, O_aligned}, 40'd0);
    sb.push_back(tword(base + 7));
    last_w = tword(base + 7);
    send_part(tword(base + 7), 0, 0);
    chk("aligned_after_8th", {39'd0, O_aligned}, 40'd1);
    send_part(tword(base + 7), 1, 3);
  endtask

  always @(negedge I_clk) begin
    if (I_rst_n && O_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 40'd1, 40'd0);
      end else begin
        logic [359:0] e;
        logic [359:0] a;
        e = sb.pop_front();
        a = outs();
        for (int l = 0; l < 9; l++) chk($sformatf("word_lane%0d", l), a[40*l +: 40], e[40*l +: 40]);
        chk("phase_on_valid", {38'd0, O_phase}, 40'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [359:0] w;
    I_rst_n = 1'b0; I_rx_locked = 1'b0; I_realign = 1'b0; I_rx_in = '0;
    repeat (3) @(posedge I_clk);
    #1;
    for (int l = 0; l < 9; l++) chk("reset_word", outs() >> (40*l), 40'd0);
    chk("reset_valid", {39'd0, O_valid}, 40'd0);
    chk("reset_aligned", {39'd0, O_aligned}, 40'd0);
    chk("reset_phase", {38'd0, O_phase}, 40'd0);
    I_rst_n = 1'b1;

    // No PLL lock: random data including markers must be ignored.
    for (int i = 0; i < 12; i++) begin
      logic [89:0] r;
      r = {$urandom, $urandom, $urandom};
      if (i % 4 == 0) r[9:0] = MARK;
      cyc(r);
    end
    chk("nolock_aligned", {39'd0, O_aligned}, 40'd0);
    chk("nolock_valid", {39'd0, O_valid}, 40'd0);
    chk("nolock_o0", O_o0_p, 40'd0);
    chk("nolock_o8", O_o8_p, 40'd0);

    // Lock, first marker two cycles later.
    I_rx_locked = 1'b1;
    cyc('0);
    cyc('0);
    train(1);
    send(dword(1), 1'b1);
    w = dword(2);
    w[40*3 +: 40] = 40'h12345_6789A;
    w[40*8 +: 40] = 40'hFF00F_F00FF;
    send(w, 1'b1);
    send(dword(3), 1'b1);

    // Lock drop on the slice-3 cycle of an otherwise complete word.
    send_part(dword(4), 0, 2);
    I_rx_locked = 1'b0;
    send_part(dword(4), 3, 3);
    chk("drop_valid", {39'd0, O_valid}, 40'd0);
    chk("drop_aligned", {39'd0, O_aligned}, 40'd0);
    chk("drop_hold_o3", O_o3_p, last_w[40*3 +: 40]);
    chk("drop_hold_o8", O_o8_p, last_w[40*8 +: 40]);

    // Relock; a bad 6th marker sends the FSM back to HUNT.
    I_rx_locked = 1'b1;
    cyc('0);
    for (int k = 0; k < 5; k++) send(tword(20 + k), 1'b0);
    w = tword(25);
    w[9:0] = 10'h000;
    send(w, 1'b0);
    chk("badmark_aligned", {39'd0, O_aligned}, 40'd0);
    train(30);
    send(dword(10), 1'b1);
    send(dword(11), 1'b1);

    // Realign on a slice-3 cycle, then re-lock one cycle off the old cadence.
    send_part(dword(12), 0, 2);
    I_realign = 1'b1;
    send_part(dword(12), 3, 3);
    I_realign = 1'b0;
    chk("realign_valid", {39'd0, O_valid}, 40'd0);
    chk("realign_aligned", {39'd0, O_aligned}, 40'd0);
    chk("realign_hold_o0", O_o0_p, last_w[39:0]);
    cyc('0);
    send_part(tword(40), 0, 0);
    chk("hunt_phase_set", {38'd0, O_phase}, 40'd1);
    send_part(tword(40), 1, 3);
    for (int k = 1; k < 7; k++) send(tword(40 + k), 1'b0);
    chk("aligned_before_8th", {39'd0, O_aligned}, 40'd0);
    sb.push_back(tword(47));
    send_part(tword(47), 0, 0);
    chk("aligned_after_8th", {39'd0, O_aligned}, 40'd1);
    send_part(tword(47), 1, 3);
    for (int k = 20; k < 23; k++) send(dword(k), 1'b1);

    @(negedge I_clk);
    I_rx_locked = 1'b0;
    repeat (4) cyc('0);
    chk("sb_drained", 40'(sb.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
